// File: rtl/ffo_pkg.sv
// ---------------------------------------------------------------------------
// ffo_pkg
// Shared types for the find-first-one dispatcher and its FIFO.
//   WORD_W           : width of a scanned word (index 0 is scanned first)
//   POS_W            : width of a bit position result
//   ffo_pos_t        : bit position type
//   ffo_word_t       : scanned word, declared [0:WORD_W-1] so index 0 is
//                      the leftmost bit
//   ffo_disp_state_e : dispatcher FSM states
// ---------------------------------------------------------------------------
package ffo_pkg;

  localparam int WORD_W = 32;
  localparam int POS_W  = 5;

  typedef logic [POS_W-1:0]  ffo_pos_t;
  typedef logic [0:WORD_W-1] ffo_word_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // waiting for a queued word, a free result slot and an idle engine
    S_LAUNCH = 2'd1,  // one-cycle start pulse to the engine
    S_BUSY   = 2'd2,  // waiting for the engine to finish
    S_HOLD   = 2'd3   // one-cycle pass for the all-zero bypass path
  } ffo_disp_state_e;

endpackage

// File: rtl/ffo_dispatch_fifo.sv
// ---------------------------------------------------------------------------
// ffo_dispatch_fifo
// Synchronous FIFO holding words waiting to be issued to the engine.
// The head entry is visible on data_o whenever empty_o is low.
//   clock, reset : clock and synchronous active-high reset
//   push_i       : write data_i (ignored while full)
//   data_i       : word to store
//   pop_i        : drop the head entry (ignored while empty)
//   data_o       : head entry
//   full_o       : no free entries
//   empty_o      : no stored entries
//   count_o      : occupancy, 0..DEPTH
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ffo_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ffo_dispatch.sv
// ---------------------------------------------------------------------------
// ffo_dispatch
// Feeder and collector around the sequential 32-bit find-first-one engine.
// Words arrive on a valid/ready stream, queue in a small FIFO, and are issued
// one at a time to the engine with a single-cycle start pulse. The engine's
// position is captured together with an all-zero flag and offered on a
// valid/ready result stream. At most one job is in flight, so results leave
// in input order.
//
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   in_valid/in_word/in_ready  : input word stream (index 0 scanned first)
//   out_valid/out_pos/out_zero/out_ready : result stream
//   eng_start, eng_b       : start pulse and operand driven to the engine
//   eng_p, eng_ready       : engine position result and idle/result-stable flag
//
// Build option FFO_DISPATCH_ZERO_BYPASS_EN: an all-zero head word is answered
// directly (out_pos=31, out_zero=1) via the HOLD state, without starting the
// engine. Without it every word goes through the engine.
// ---------------------------------------------------------------------------
module ffo_dispatch
  import ffo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [0:WORD_W-1] in_word,
  output logic              in_ready,
  output logic              out_valid,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_zero,
  input  logic              out_ready,
  output logic              eng_start,
  output logic [0:WORD_W-1] eng_b,
  input  logic [POS_W-1:0]  eng_p,
  input  logic              eng_ready
);

  ffo_disp_state_e state_q, state_d;
  ffo_word_t       cur_word_q, cur_word_d;
  logic            first_busy_q, first_busy_d;
  logic            out_valid_q, out_valid_d;
  ffo_pos_t        out_pos_q, out_pos_d;
  logic            out_zero_q, out_zero_d;

  ffo_word_t              head_word;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count_unused;  // occupancy, kept for debug visibility
  logic                   can_issue;

  assign in_ready = !fifo_full && !reset;

  ffo_dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (in_valid && in_ready),
    .data_i  (in_word),
    .pop_i   (fifo_pop),
    .data_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  // A new job may start only when the result slot is free and the engine is
  // idle; this is what keeps a single job in flight.
  assign can_issue = !fifo_empty && !out_valid_q && eng_ready;

  always_comb begin
    state_d      = state_q;
    cur_word_d   = cur_word_q;
    first_busy_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_pos_d    = out_pos_q;
    out_zero_d   = out_zero_q;
    fifo_pop     = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          fifo_pop   = 1'b1;
          cur_word_d = head_word;
`ifdef FFO_DISPATCH_ZERO_BYPASS_EN
          if (head_word == '0) begin
            out_valid_d = 1'b1;
            out_pos_d   = ffo_pos_t'(WORD_W - 1);
            out_zero_d  = 1'b1;
            state_d     = S_HOLD;
          end else begin
            state_d = S_LAUNCH;
          end
`else
          state_d = S_LAUNCH;
`endif
        end
      end
      S_LAUNCH: begin
        state_d      = S_BUSY;
        first_busy_d = 1'b1;
      end
      S_BUSY: begin
        // The engine only drops ready the cycle after start, so the first
        // BUSY cycle still sees the stale idle flag and must be ignored.
        if (!first_busy_q && eng_ready) begin
          out_valid_d = 1'b1;
          out_pos_d   = eng_p;
          out_zero_d  = (cur_word_q == '0);
          state_d     = S_IDLE;
        end
      end
`ifdef FFO_DISPATCH_ZERO_BYPASS_EN
      S_HOLD: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_word_q   <= '0;
      first_busy_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pos_q    <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_word_q   <= cur_word_d;
      first_busy_q <= first_busy_d;
      out_valid_q  <= out_valid_d;
      out_pos_q    <= out_pos_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign eng_start = (state_q == S_LAUNCH);
  assign eng_b     = cur_word_q;  // held between launches so the engine input never moves
  assign out_valid = out_valid_q;
  assign out_pos   = out_pos_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_ffo_dispatch.sv
// ---------------------------------------------------------------------------
// tb_ffo_dispatch
// Self-checking bench for ffo_dispatch. A behavioural engine answers start
// pulses: busy for k+1 cycles after the launch cycle, then ready with p=k
// (k = first-one index, 31 for an all-zero word). Directed vectors carry
// hand-computed position, zero flag and push-to-valid latency; hand-written
// sequences cover fill/stall ordering and reset during a job.
// ---------------------------------------------------------------------------
module tb_ffo_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [0:31] in_word;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_pos;
  logic        out_zero;
  logic        out_ready;
  logic        eng_start;
  logic [0:31] eng_b;
  logic [4:0]  eng_p;
  logic        eng_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ffo_dispatch #(.DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pos   (out_pos),
    .out_zero  (out_zero),
    .out_ready (out_ready),
    .eng_start (eng_start),
    .eng_b     (eng_b),
    .eng_p     (eng_p),
    .eng_ready (eng_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef FFO_DISPATCH_ZERO_BYPASS_EN
  localparam int ZERO_LAT    = 2;
  localparam int ZERO_STARTS = 0;
`else
  localparam int ZERO_LAT    = 36;
  localparam int ZERO_STARTS = 1;
`endif

  // ---------------- engine model ----------------
  function automatic logic [4:0] first_one(input logic [0:31] w);
    for (int i = 0; i < 32; i++) if (w[i]) return 5'(i);
    return 5'd31;
  endfunction

  logic [4:0] eng_pos_m;
  int         eng_cnt;

  always @(posedge clock) begin
    if (reset) begin
      eng_ready <= 1'b1;
      eng_p     <= 5'd0;
      eng_cnt   <= 0;
      eng_pos_m <= 5'd0;
    end else if (eng_start) begin
      eng_ready <= 1'b0;
      eng_cnt   <= int'(first_one(eng_b));
      eng_pos_m <= first_one(eng_b);
    end else if (!eng_ready) begin
      if (eng_cnt == 0) begin
        eng_ready <= 1'b1;
        eng_p     <= eng_pos_m;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // ---------------- monitor ----------------
  int          n_starts = 0;
  logic [0:31] last_start_b;
  logic [4:0]  got_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (eng_start) begin
        n_starts++;
        last_start_b = eng_b;
      end
      if (out_valid && out_ready) got_q.push_back(out_pos);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic push_word(input logic [0:31] w, output int pc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("push_accepted", 32'(in_ready), 32'd1);
    pc = cyc;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid was first seen.
  task automatic wait_valid(input int budget, output int vc);
    bit ok;
    ok = 1'b0;
    vc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        vc = cyc;
        break;
      end
    end
    check("result_within_budget", 32'(ok), 32'd1);
  endtask

  function automatic logic [0:31] one_hot(input int k);
    logic [0:31] w;
    w    = '0;
    w[k] = 1'b1;
    return w;
  endfunction

  typedef struct {
    string       name;
    logic [0:31] word;
    logic [4:0]  pos;
    logic        zero;
    int          lat;     // push cycle to first out_valid cycle
    int          starts;  // engine starts caused by this word
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, vc, s0, r0;

    vecs[0] = '{"idx5",     32'h0400_0000, 5'd5,  1'b0, 10,       1};
    vecs[1] = '{"zero",     32'h0000_0000, 5'd31, 1'b1, ZERO_LAT, ZERO_STARTS};
    vecs[2] = '{"idx31",    32'h0000_0001, 5'd31, 1'b0, 36,       1};
    vecs[3] = '{"idx0",     32'h8020_0001, 5'd0,  1'b0, 5,        1};
    vecs[4] = '{"idx3",     32'h1008_0000, 5'd3,  1'b0, 8,        1};
    vecs[5] = '{"allones",  32'hFFFF_FFFF, 5'd0,  1'b0, 5,        1};
    vecs[6] = '{"idx30",    32'h0000_0003, 5'd30, 1'b0, 35,       1};

    // ---------------- reset ----------------
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pos",   32'(out_pos),   32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_b",     eng_b,          32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // ---------------- directed vectors ----------------
    foreach (vecs[i]) begin
      s0 = n_starts;
      push_word(vecs[i].word, pc);
      wait_valid(100, vc);
      check($sformatf("%s_pos", vecs[i].name),  32'(out_pos),  32'(vecs[i].pos));
      check($sformatf("%s_zero", vecs[i].name), 32'(out_zero), 32'(vecs[i].zero));
      check($sformatf("%s_latency", vecs[i].name), 32'(vc - pc), 32'(vecs[i].lat));
      check($sformatf("%s_starts", vecs[i].name), 32'(n_starts - s0), 32'(vecs[i].starts));
      if (vecs[i].starts == 1)
        check($sformatf("%s_eng_b", vecs[i].name), last_start_b, vecs[i].word);
      @(posedge clock);
      #1;
      check($sformatf("%s_consumed", vecs[i].name), 32'(out_valid), 32'd0);
    end

    // ---------------- fill and stall ----------------
    got_q.delete();
    s0 = n_starts;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(one_hot(k), pc);
    repeat (10) @(posedge clock);
    #1;
    in_valid = 1'b1;
    in_word  = one_hot(5);
    @(negedge clock);
    check("stall_in_ready",  32'(in_ready),  32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_hold_pos",  32'(out_pos),   32'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    push_word(one_hot(5), pc);
    for (int n = 0; n < 300 && got_q.size() < 6; n++) @(negedge clock);
    check("stall_result_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check($sformatf("stall_order_%0d", i), 32'(got_q[i]), 32'(i));
    check("stall_starts", 32'(n_starts - s0), 32'd6);
    @(posedge clock);
    #1;

    // ---------------- reset mid-job ----------------
    push_word(one_hot(20), pc);
    push_word(one_hot(1), pc);
    push_word(one_hot(2), pc);
    push_word(one_hot(3), pc);
    repeat (2) @(posedge clock);
    #1;
    s0 = n_starts;
    r0 = got_q.size();
    reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    repeat (40) @(negedge clock);
    check("midrst_no_starts",  32'(n_starts - s0),     32'd0);
    check("midrst_no_results", 32'(got_q.size() - r0), 32'd0);
    @(posedge clock);
    #1;
    push_word(one_hot(7), pc);
    wait_valid(100, vc);
    check("midrst_new_pos",     32'(out_pos),  32'd7);
    check("midrst_new_zero",    32'(out_zero), 32'd0);
    check("midrst_new_latency", 32'(vc - pc),  32'd12);
    @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ffo_dispatch.md
# ffo_dispatch

Feeder and collector for the sequential 32-bit find-first-one engine. Accepts words on a valid/ready stream, buffers them in a small FIFO, and issues them one at a time to the engine with a start pulse. It captures each engine result, adds an all-zero flag, and presents it on a valid/ready result stream. The block sits directly around the engine: upstream it drives the engine's `start`/`b`, downstream it consumes the engine's `p`/`ready`.

## Interface
- `DEPTH`, 4: input FIFO entries; power of two, at least 2.
- `clock`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input word offered.
- `in_word`  in  [0:31]  word to scan; index 0 is scanned first.
- `in_ready`  out  1  FIFO can accept a word.
- `out_valid`  out  1  result register holds a result.
- `out_pos`  out  [4:0]  index of the first 1; 31 for an all-zero word.
- `out_zero`  out  1  scanned word was all zeros.
- `out_ready`  in  1  consumer accepts the result.
- `eng_start`  out  1  single-cycle start pulse to the engine.
- `eng_b`  out  [0:31]  word presented to the engine.
- `eng_p`  in  [4:0]  engine position result.
- `eng_ready`  in  1  engine idle; also means the result is stable.

## Operation
- **FIFO.**
  - `in_ready = !full && !reset`.
  - A push occurs when `in_valid && in_ready`.
  - Push and pop in the same cycle are legal at any non-full occupancy.
  - A push into an empty FIFO is visible for pop on the next cycle.
- **FSM states.** IDLE, LAUNCH, BUSY, HOLD.
- **IDLE.**
  - Condition to advance: FIFO non-empty, `out_valid==0`, and `eng_ready==1`.
  - When the condition holds, pop the head into register `cur_word` and go to LAUNCH.
- **LAUNCH.**
  - `eng_start=1` and `eng_b=cur_word` for exactly one cycle.
  - Always goes to BUSY.
- **BUSY.**
  - Wait for `eng_ready==1`.
  - The first BUSY cycle ignores `eng_ready`, because the engine drops `ready` the cycle after start.
  - On `eng_ready==1`, capture `out_pos=eng_p` and `out_zero=(cur_word==0)`, set `out_valid`, and go to IDLE.
- **HOLD.** Reserved for the bypass path (see Configuration); unreachable without the macro.
- **Output register.**
  - A result is consumed when `out_valid && out_ready`.
  - The consume cycle clears `out_valid`.
  - `out_pos` and `out_zero` stay stable while `out_valid && !out_ready`.
- **eng_b.** Held at `cur_word` outside LAUNCH, so the engine input is always stable.
- **Position rule.** `out_pos` is the lowest index i with `word[i]==1`; an all-zero word gives `out_pos=31`, `out_zero=1`.
- **Ordering.** Results leave in input order; there is at most one job in flight.
- **Reset mid-operation.**
  - FIFO is emptied, FSM goes to IDLE, `out_valid` is cleared, and the in-flight job is discarded.
  - The engine shares `reset`.

## Timing
- **Reset values.** `in_ready=0` while reset is asserted and 1 after; `out_valid=0`, `out_pos=0`, `out_zero=0`, `eng_start=0`, `eng_b=0`.
- **Launch latency.** With an empty FIFO and an idle engine, a word pushed in cycle t gives the pop in cycle t+1 and LAUNCH in cycle t+2.
- **Engine latency.** With first 1 at index k and launch cycle L:
  - engine busy from L+1 to L+1+k;
  - `eng_ready` high at L+2+k;
  - `out_valid` high at L+3+k.
- **All-zero word.** `out_valid` high at L+34.
- **Back-to-back.** The next pop can occur in the cycle the previous result is consumed, provided `out_valid` is 0 at that edge; otherwise the earliest pop is the cycle after the consume.

## Configuration
- `FFO_DISPATCH_ZERO_BYPASS_EN` defined:
  - An all-zero head word is popped directly into the result register without using the engine.
  - The result is `out_pos=31`, `out_zero=1`, `out_valid` asserted the cycle after the pop.
  - The FSM passes through HOLD for one cycle, with no `eng_start`.
  - Nonzero words behave as above.
- Undefined: every word goes through the engine, and HOLD logic is omitted.

## Structure
- **Package `ffo_pkg`:**
  - `WORD_W=32`, `POS_W=5`;
  - `ffo_pos_t`;
  - the dispatcher state enum `ffo_disp_state_e`.
- **Sub-module `ffo_dispatch_fifo`:** parameterised synchronous FIFO with push, pop, full and empty, plus an occupancy count of `$clog2(DEPTH)+1` bits.

## Test plan
- **Single word.** Push word with only index 5 set → `out_valid` 8 cycles after LAUNCH; `out_pos=5`, `out_zero=0`.
- **Zero word, macro undefined.** Push all-zero → `out_pos=31`, `out_zero=1` at L+34.
- **Zero word, macro defined.** Same push → `out_pos=31`, `out_zero=1` the cycle after the pop; `eng_start` never asserted.
- **Index-31 word.** Push word with only index 31 set → `out_pos=31`, `out_zero=0`.
- **Fill and stall.** Hold `out_ready=0` and push DEPTH+2 words with first-1 indices 0,1,2,… → `in_ready` drops after 4 pushes into the FIFO plus 1 in flight; release `out_ready` → results 0,1,2,… in order, none lost.
- **Reset mid-job.** Assert `reset` during BUSY with 3 words queued → next cycle `out_valid=0` and FIFO empty; a new push produces a correct result.
